fix_mul_vec_pipe: RTL and testbench
===================================

Name:
fix_mul_vec_pipe

Overview:
Parametrised, pipelined N-lane signed fixed-point elementwise vector multiplier, successor to the fixed 25-lane vector multiplier in the CNN datapath. Adds a valid/ready handshake with full backpressure, configurable rounding and saturation, and per-lane plus sticky overflow reporting. Sits between the window/weight buffers and the adder tree in the convolution engine.

Parameters:
LANES, 25, number of parallel lanes (1..64)
WIDTH, 16, total signed fixed-point width per lane
POINT_WIDTH, 8, fractional bits (1..WIDTH-1)
ROUND, 1, 1 = round-half-up before shift; 0 = truncate (floor)
SATURATE, 1, 1 = clamp to signed WIDTH range; 0 = wrap (keep low WIDTH bits)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
inA  in  WIDTH*LANES  lane i at bits [i*WIDTH +: WIDTH], signed Q format
inB  in  WIDTH*LANES  same packing as inA
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts beat
outP  out  WIDTH*LANES  products, same packing
out_ovf  out  LANES  bit i = lane i saturated/wrapped in this beat
ovf_sticky  out  1  OR of all out_ovf since last clear
ovf_clr  in  1  clears ovf_sticky

Behaviour:
- Clock clk, synchronous active-high reset rst; all state updates on rising edge only.
- Two-stage pipeline: S1 registers full 2*WIDTH signed product per lane; S2 registers rounded/shifted/saturated WIDTH result plus overflow flags.
- Latency: beat accepted at edge k appears on outP/out_valid after edge k+2 when no stall. Throughput 1 beat/cycle.
- Handshake: transfer on in_valid & in_ready; output transfer on out_valid & out_ready. s2_adv = !s2_valid | out_ready; s1_adv = !s1_valid | s2_adv; in_ready = s1_adv (combinational, no dependency on in_valid).
- Stall: while out_valid & !out_ready, outP/out_ovf/out_valid hold stable; no beat is dropped or duplicated. Bubbles collapse (S1 may fill while S2 stalled).
- Arithmetic per lane: p = signed(A)*signed(B), 2*WIDTH bits. If ROUND: p += 2^(POINT_WIDTH-1). r = p >>> POINT_WIDTH (arithmetic). Overflow when r outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- SATURATE=1: overflowing r clamps to 0x7FF..F or 0x800..0; SATURATE=0: outP = r[WIDTH-1:0]. out_ovf bit set in both cases.
- ovf_sticky: set on the edge an S2 beat with any out_ovf bit is transferred out; ovf_clr clears; simultaneous set and clear -> set wins.
- Reset values: out_valid=0, outP=0, out_ovf=0, ovf_sticky=0, internal valids=0; in_ready=1 the cycle after reset deasserts. Reset mid-operation discards all in-flight beats; in_ready is 0 while rst=1.
- Data registers in S1/S2 only load on their advance; no X propagates to outP when out_valid=0 (outP holds last value).

Test Plan:
- Basic (W=16,P=8): lane0 A=0x0180 (1.5), B=0x0200 (2.0); lane1 A=0xFF00 (-1.0), B=0x0080 (0.5), out_ready=1 -> two cycles later outP lane0=0x0300, lane1=0xFF80, out_ovf=0.
- Saturation: A=0x7F00, B=0x0200 -> 0x7FFF, out_ovf[i]=1, ovf_sticky=1; A=0x8000, B=0x0200 -> 0x8000, out_ovf=1; SATURATE=0 build: first case gives 0xFE00, out_ovf=1.
- Rounding: A=0x0001, B=0x0080 -> ROUND=1 gives 0x0001, ROUND=0 gives 0x0000; A=0xFFFF, B=0x0080 -> ROUND=1 gives 0x0000, ROUND=0 gives 0xFFFF.
- Backpressure: stream 10 beats with in_valid=1 and random out_ready (~50%) -> all 10 results in order, none lost or duplicated; outP stable while stalled; in_ready=0 only when S1 and S2 full and out_ready=0.
- Reset mid-stream: assert rst with 2 beats in flight -> next cycle out_valid=0, outP=0, ovf_sticky=0; after release first output is first post-reset input.
- Sticky clear: overflow beat transferred in the same cycle as ovf_clr=1 -> ovf_sticky remains 1; ovf_clr alone next cycle -> 0. Repeat Basic with LANES=1 and LANES=64.

Source files
------------

// File: rtl/fix_mul_vec_pipe.sv
// fix_mul_vec_pipe: pipelined N-lane signed fixed-point elementwise multiplier.
//
// Stage 1 registers the full 2*WIDTH-bit product of each lane. Stage 2
// registers the rounded, shifted and saturated (or wrapped) WIDTH-bit result
// together with per-lane overflow flags. A valid/ready handshake with full
// backpressure joins the stages. Bubbles collapse, so stage 1 can still fill
// while stage 2 is stalled.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_valid    input beat valid
//   in_ready    block can accept a beat (combinational, 0 while rst=1)
//   inA, inB    lane i at bits [i*WIDTH +: WIDTH], signed Q(WIDTH-POINT_WIDTH).POINT_WIDTH
//   out_valid   output beat valid
//   out_ready   downstream accepts the beat
//   outP        products, same packing as inA
//   out_ovf     bit i = lane i saturated/wrapped in this beat
//   ovf_sticky  OR of all transferred out_ovf since the last clear
//   ovf_clr     clears ovf_sticky (a simultaneous set wins)
module fix_mul_vec_pipe #(
   parameter int unsigned LANES       = 25,
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned POINT_WIDTH = 8,
   parameter int unsigned ROUND       = 1,
   parameter int unsigned SATURATE    = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH*LANES-1:0]   inA,
   input  logic [WIDTH*LANES-1:0]   inB,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH*LANES-1:0]   outP,
   output logic [LANES-1:0]         out_ovf,
   output logic                     ovf_sticky,
   input  logic                     ovf_clr
);

   localparam int unsigned PW = 2 * WIDTH;        // full product width
   localparam int unsigned RW = PW - POINT_WIDTH; // width after the fractional shift
   localparam int unsigned HW = RW - WIDTH + 1;   // bits that must all agree to fit WIDTH

   localparam logic [PW-1:0]    RoundInc = (ROUND != 0) ? (PW'(1) << (POINT_WIDTH - 1)) : '0;
   localparam logic [WIDTH-1:0] MaxPos   = {1'b0, {(WIDTH - 1){1'b1}}};
   localparam logic [WIDTH-1:0] MinNeg   = {1'b1, {(WIDTH - 1){1'b0}}};

   logic s1_adv, s2_adv, in_fire;

   logic                   s1_valid_q, s1_valid_d;
   logic [PW-1:0]          s1_prod_q [LANES];
   logic [PW-1:0]          s1_prod_d [LANES];

   logic                   s2_valid_q, s2_valid_d;
   logic [WIDTH*LANES-1:0] s2_res_q, s2_res_d;
   logic [LANES-1:0]       s2_ovf_q, s2_ovf_d;

   logic                   sticky_q, sticky_d;

   // Stage 1 temporaries
   logic [PW-1:0]          a_ext, b_ext;
   // Stage 2 temporaries
   logic [PW-1:0]          p_rnd;
   logic [RW-1:0]          r_sh;
   logic [HW-1:0]          r_top;
   logic                   lane_ovf;

   // Handshake: a stage advances when it is empty or its consumer advances.
   always_comb begin
      s2_adv   = !s2_valid_q || out_ready;
      s1_adv   = !s1_valid_q || s2_adv;
      in_ready = s1_adv && !rst;
      in_fire  = in_valid && in_ready;
   end

   // Stage 1: sign-extend both operands to PW bits and multiply.
   always_comb begin
      s1_valid_d = s1_adv ? in_fire : s1_valid_q;
      a_ext      = '0;
      b_ext      = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         s1_prod_d[i] = s1_prod_q[i];
         if (in_fire) begin
            a_ext = {{WIDTH{inA[i*WIDTH+WIDTH-1]}}, inA[i*WIDTH +: WIDTH]};
            b_ext = {{WIDTH{inB[i*WIDTH+WIDTH-1]}}, inB[i*WIDTH +: WIDTH]};
            s1_prod_d[i] = $signed(a_ext) * $signed(b_ext);
         end
      end
   end

   // Stage 2: round, shift, range-check, then clamp or wrap.
   always_comb begin
      s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
      s2_res_d   = s2_res_q;
      s2_ovf_d   = s2_ovf_q;
      p_rnd      = '0;
      r_sh       = '0;
      r_top      = '0;
      lane_ovf   = 1'b0;
      if (s2_adv && s1_valid_q) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            // The maximum product magnitude is 2^(PW-2), so adding the rounding
            // constant cannot overflow PW bits.
            p_rnd = s1_prod_q[i] + RoundInc;
            // Keeping only the low RW bits of the shifted value gives exactly
            // p_rnd[PW-1:POINT_WIDTH], the same bits an arithmetic shift keeps.
            r_sh  = RW'(p_rnd >> POINT_WIDTH);
            r_top = r_sh[RW-1:WIDTH-1];
            // The result fits in WIDTH bits only if the sign bit and all bits
            // above it are identical.
            lane_ovf    = !((&r_top) || !(|r_top));
            s2_ovf_d[i] = lane_ovf;
            if (lane_ovf && (SATURATE != 0)) begin
               s2_res_d[i*WIDTH +: WIDTH] = r_sh[RW-1] ? MinNeg : MaxPos;
            end else begin
               s2_res_d[i*WIDTH +: WIDTH] = r_sh[WIDTH-1:0];
            end
         end
      end
   end

   // Sticky overflow: set on the transfer of an overflowing beat; set beats clear.
   always_comb begin
      sticky_d = sticky_q;
      if (s2_valid_q && out_ready && (|s2_ovf_q)) begin
         sticky_d = 1'b1;
      end else if (ovf_clr) begin
         sticky_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_res_q   <= '0;
         s2_ovf_q   <= '0;
         sticky_q   <= 1'b0;
         for (int unsigned i = 0; i < LANES; i++) begin
            s1_prod_q[i] <= '0;
         end
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s2_res_q   <= s2_res_d;
         s2_ovf_q   <= s2_ovf_d;
         sticky_q   <= sticky_d;
         for (int unsigned i = 0; i < LANES; i++) begin
            s1_prod_q[i] <= s1_prod_d[i];
         end
      end
   end

   assign out_valid  = s2_valid_q;
   assign outP       = s2_res_q;
   assign out_ovf    = s2_ovf_q;
   assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_fix_mul_vec_pipe.sv
// tb_fix_mul_vec_pipe: self-checking bench for fix_mul_vec_pipe.
//
// Main instance: default build (25 lanes, Q8.8, round, saturate), exercised with
// directed beats and a randomized handshake stream checked against an integer
// reference model and an in-order scoreboard. A second single-lane instance
// (truncate, wrap) covers the alternative arithmetic build.
module tb_fix_mul_vec_pipe;

   localparam int unsigned Lanes = 25;
   localparam int unsigned Width = 16;
   localparam int unsigned Point = 8;
   localparam int unsigned Vw    = Lanes * Width;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic             in_valid, in_ready, out_valid, out_ready;
   logic [Vw-1:0]    inA, inB, outP;
   logic [Lanes-1:0] out_ovf;
   logic             ovf_sticky, ovf_clr;

   logic             t_in_valid, t_in_ready, t_out_valid, t_out_ready;
   logic [Width-1:0] t_inA, t_inB, t_outP;
   logic [0:0]       t_out_ovf;
   logic             t_ovf_sticky, t_ovf_clr;

   fix_mul_vec_pipe #(
      .LANES(Lanes), .WIDTH(Width), .POINT_WIDTH(Point), .ROUND(1), .SATURATE(1)
   ) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .inA(inA), .inB(inB), .out_valid(out_valid), .out_ready(out_ready),
      .outP(outP), .out_ovf(out_ovf), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
   );

   fix_mul_vec_pipe #(
      .LANES(1), .WIDTH(Width), .POINT_WIDTH(Point), .ROUND(0), .SATURATE(0)
   ) u_dut_trunc (
      .clk(clk), .rst(rst), .in_valid(t_in_valid), .in_ready(t_in_ready),
      .inA(t_inA), .inB(t_inB), .out_valid(t_out_valid), .out_ready(t_out_ready),
      .outP(t_outP), .out_ovf(t_out_ovf), .ovf_sticky(t_ovf_sticky), .ovf_clr(t_ovf_clr)
   );

   typedef struct {
      logic [Vw-1:0]    p;
      logic [Lanes-1:0] o;
   } beat_t;

   beat_t sb[$];
   int    nchecks = 0;
   int    nerr    = 0;
   bit    exp_sticky;
   bit    last_acc;
   int    sent;

   task automatic check_val(input string tag, input logic [1023:0] got,
                            input logic [1023:0] exp);
      nchecks++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: exact integer product, optional half-up rounding, floor shift,
   // then range check. Returns {ovf, value}.
   function automatic logic [16:0] ref_lane(input logic [15:0] a, input logic [15:0] b,
                                            input bit rnd, input bit sat);
      longint p, r;
      p = longint'($signed(a)) * longint'($signed(b));
      if (rnd) p = p + (longint'(1) << (Point - 1));
      r = p >>> Point;
      if (r > 32767)  return {1'b1, sat ? 16'h7fff : 16'(r)};
      if (r < -32768) return {1'b1, sat ? 16'h8000 : 16'(r)};
      return {1'b0, 16'(r)};
   endfunction

   function automatic beat_t ref_vec(input logic [Vw-1:0] a, input logic [Vw-1:0] b);
      beat_t       e;
      logic [16:0] l;
      for (int i = 0; i < Lanes; i++) begin
         l = ref_lane(a[i*Width +: Width], b[i*Width +: Width], 1'b1, 1'b1);
         e.p[i*Width +: Width] = l[15:0];
         e.o[i]                = l[16];
      end
      return e;
   endfunction

   // Mix full-range lanes (overflow likely) with small lanes (never overflow).
   function automatic logic [Vw-1:0] rand_vec();
      logic [Vw-1:0] v;
      logic [11:0]   s;
      for (int i = 0; i < Lanes; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            v[i*Width +: Width] = 16'($urandom);
         end else begin
            s = 12'($urandom);
            v[i*Width +: Width] = {{4{s[11]}}, s};
         end
      end
      return v;
   endfunction

   // One clock of the randomized phase. Inputs are already driven.
   task automatic tick();
      bit sticky_nxt;
      bit set;
      #1;
      check_val("in_ready", in_ready, (sb.size() == 2 && !out_ready) ? 1'b0 : 1'b1);
      set = 1'b0;
      if (sb.size() == 0) begin
         check_val("idle_valid", out_valid, 1'b0);
      end else if (out_valid) begin
         check_val("outP", outP, sb[0].p);
         check_val("out_ovf", out_ovf, sb[0].o);
         if (out_ready) begin
            set = |sb[0].o;
            void'(sb.pop_front());
         end
      end
      last_acc = in_valid && in_ready;
      if (last_acc) sb.push_back(ref_vec(inA, inB));
      sticky_nxt = set ? 1'b1 : (ovf_clr ? 1'b0 : exp_sticky);
      @(posedge clk);
      #1;
      exp_sticky = sticky_nxt;
      check_val("ovf_sticky", ovf_sticky, exp_sticky);
   endtask

   // Single beat into an empty pipe with out_ready=1; checks two-edge latency.
   task automatic direct_beat(input logic [Vw-1:0] a, input logic [Vw-1:0] b);
      inA = a; inB = b; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      check_val("acc_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check_val("lat1_valid", out_valid, 1'b0);
      @(posedge clk);
      #1;
      check_val("lat2_valid", out_valid, 1'b1);
   endtask

   task automatic t_beat(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] ep, input logic eo);
      t_inA = a; t_inB = b; t_in_valid = 1'b1;
      @(posedge clk);
      #1;
      t_in_valid = 1'b0;
      @(posedge clk);
      #1;
      check_val("t_valid", t_out_valid, 1'b1);
      check_val("t_outP", t_outP, ep);
      check_val("t_ovf", t_out_ovf, eo);
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [Vw-1:0] va, vb;
      beat_t         e;
      rst = 1'b1; in_valid = 1'b0; inA = '0; inB = '0; out_ready = 1'b1; ovf_clr = 1'b0;
      t_in_valid = 1'b0; t_inA = '0; t_inB = '0; t_out_ready = 1'b1; t_ovf_clr = 1'b0;
      exp_sticky = 1'b0; last_acc = 1'b0; sent = 0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_valid", out_valid, 1'b0);
      check_val("rst_outP", outP, '0);
      check_val("rst_ovf", out_ovf, '0);
      check_val("rst_sticky", ovf_sticky, 1'b0);
      check_val("rst_ready", in_ready, 1'b0);
      rst = 1'b0;
      #1;
      check_val("post_rst_ready", in_ready, 1'b1);

      // Basic: 1.5*2.0 and -1.0*0.5
      va = '0; vb = '0;
      va[15:0] = 16'h0180; vb[15:0] = 16'h0200;
      va[31:16] = 16'hff00; vb[31:16] = 16'h0080;
      direct_beat(va, vb);
      check_val("basic_l0", outP[15:0], 16'h0300);
      check_val("basic_l1", outP[31:16], 16'hff80);
      check_val("basic_ovf", out_ovf, '0);
      e = ref_vec(va, vb);
      check_val("basic_vec", outP, e.p);
      @(posedge clk);
      #1;
      check_val("basic_sticky", ovf_sticky, 1'b0);

      // Rounding half-up
      va = '0; vb = '0;
      va[15:0] = 16'h0001; vb[15:0] = 16'h0080;
      va[31:16] = 16'hffff; vb[31:16] = 16'h0080;
      direct_beat(va, vb);
      check_val("round_pos", outP[15:0], 16'h0001);
      check_val("round_neg", outP[31:16], 16'h0000);
      @(posedge clk);
      #1;

      // Saturation both directions
      va = '0; vb = '0;
      va[15:0] = 16'h7f00; vb[15:0] = 16'h0200;
      va[31:16] = 16'h8000; vb[31:16] = 16'h0200;
      direct_beat(va, vb);
      check_val("sat_pos", outP[15:0], 16'h7fff);
      check_val("sat_neg", outP[31:16], 16'h8000);
      check_val("sat_ovf", out_ovf, 25'h3);
      @(posedge clk);
      #1;
      check_val("sat_sticky", ovf_sticky, 1'b1);

      // Sticky: set and clear together -> set wins; clear alone -> cleared
      direct_beat(va, vb);
      ovf_clr = 1'b1;
      @(posedge clk);
      #1;
      check_val("sticky_set_wins", ovf_sticky, 1'b1);
      @(posedge clk);
      #1;
      check_val("sticky_cleared", ovf_sticky, 1'b0);
      ovf_clr = 1'b0;
      exp_sticky = 1'b0;

      // Backpressure: 10 beats with random out_ready
      for (int c = 0; c < 300 && sent < 10; c++) begin
         if (!in_valid) begin
            inA = rand_vec(); inB = rand_vec();
         end
         in_valid  = 1'b1;
         out_ready = 1'($urandom_range(0, 1));
         tick();
         if (last_acc) begin
            sent++;
            in_valid = 1'b0;
         end
      end
      check_val("stream_sent", sent, 10);

      // Random valid, ready and clear
      for (int c = 0; c < 200; c++) begin
         if (!in_valid || last_acc) begin
            inA = rand_vec(); inB = rand_vec();
            in_valid = 1'($urandom_range(0, 1));
         end
         out_ready = 1'($urandom_range(0, 1));
         ovf_clr   = ($urandom_range(0, 7) == 0);
         tick();
      end

      in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
      for (int c = 0; c < 10 && sb.size() != 0; c++) tick();
      check_val("drain_empty", sb.size(), 0);
      repeat (3) tick();

      // Force an overflow beat through so the sticky flag is set before reset
      va = '0; vb = '0;
      va[15:0] = 16'h7f00; vb[15:0] = 16'h0200;
      inA = va; inB = vb; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int c = 0; c < 4; c++) tick();
      check_val("pre_rst_sticky", ovf_sticky, 1'b1);

      // Reset with two beats in flight
      out_ready = 1'b0; in_valid = 1'b1;
      inA = rand_vec(); inB = rand_vec();
      tick();
      inA = rand_vec(); inB = rand_vec();
      tick();
      check_val("inflight", sb.size(), 2);
      rst = 1'b1; in_valid = 1'b0;
      #1;
      check_val("rst_ready_hi", in_ready, 1'b0);
      @(posedge clk);
      #1;
      check_val("mid_rst_valid", out_valid, 1'b0);
      check_val("mid_rst_outP", outP, '0);
      check_val("mid_rst_sticky", ovf_sticky, 1'b0);
      check_val("mid_rst_ovf", out_ovf, '0);
      rst = 1'b0;
      sb.delete();
      exp_sticky = 1'b0;
      out_ready = 1'b1;
      inA = rand_vec(); inB = rand_vec(); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int c = 0; c < 6 && sb.size() != 0; c++) tick();
      check_val("post_rst_drain", sb.size(), 0);

      // Truncate/wrap single-lane build
      t_beat(16'h0180, 16'h0200, 16'h0300, 1'b0);
      t_beat(16'hff00, 16'h0080, 16'hff80, 1'b0);
      t_beat(16'h0001, 16'h0080, 16'h0000, 1'b0);
      t_beat(16'hffff, 16'h0080, 16'hffff, 1'b0);
      t_beat(16'h7f00, 16'h0200, 16'hfe00, 1'b1);
      @(posedge clk);
      #1;
      check_val("t_sticky", t_ovf_sticky, 1'b1);

      $display("CHECKS %0d ERRORS %0d", nchecks, nerr);
      $finish;
   end

endmodule
